// File: rtl/goose_pkg.sv
// Shared constants, state encoding and helpers for the goose collision detector.
package goose_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int HIT_THRESHOLD_DEF = 4;
  localparam int GRACE_FRAMES_DEF  = 30;
  localparam int CNT_W_DEF         = 12;

  typedef enum logic [1:0] {
    ST_GRACE = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2
  } state_e;

  // Grace counter width; a zero-frame grace period still needs a 1-bit register.
  function automatic int grace_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/goose_hit_detector_frame_overlap_acc.sv
// Per-frame saturating overlap counter with first-overlap pixel capture.
module frame_overlap_acc
  import goose_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             ov_i,
  input  logic             frame_tick_i,
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  output logic [CNT_W-1:0] acc_next_o,
  output logic [9:0]       fx_o,
  output logic [9:0]       fy_o,
  output logic             valid_o
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic [CNT_W-1:0] acc_q;
  logic [9:0]       fx_q, fy_q;
  logic             valid_q;

  always_comb begin
    acc_next_o = acc_q;
    if (acc_q != ACC_MAX) begin
      acc_next_o = acc_q + {{(CNT_W-1){1'b0}}, ov_i};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      acc_q   <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      valid_q <= 1'b0;
    end else if (frame_tick_i) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q <= acc_next_o;
      if (ov_i && !valid_q) begin
        fx_q    <= x_i;
        fy_q    <= y_i;
        valid_q <= 1'b1;
      end
    end
  end

  assign fx_o    = fx_q;
  assign fy_o    = fy_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/goose_hit_detector.sv
// Once-per-frame goose/obstacle collision decision with a post-reset grace period.
module goose_hit_detector
  import goose_pkg::*;
#(
  parameter int HIT_THRESHOLD = HIT_THRESHOLD_DEF,
  parameter int GRACE_FRAMES  = GRACE_FRAMES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             frame_tick,
  input  logic             video_on,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             goose,
  input  logic             obstacle,
  output logic             check_hit,
  output logic             hit_pulse,
  output logic [9:0]       hit_x,
  output logic [9:0]       hit_y,
  output logic [CNT_W-1:0] overlap_count
);

  localparam int              GW         = grace_w(GRACE_FRAMES);
  localparam logic [GW-1:0]   GRACE_INIT = GW'(GRACE_FRAMES);
  localparam state_e          RESET_ST   = (GRACE_FRAMES == 0) ? ST_ARMED : ST_GRACE;

  logic             ov;
  logic [CNT_W-1:0] acc_next;
  logic [9:0]       fx, fy;
  logic             f_valid;
  logic             over_thr;

  state_e           state_q, state_d;
  logic [GW-1:0]    grace_q, grace_d;
  logic             check_hit_q, check_hit_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic [9:0]       hit_x_q, hit_x_d;
  logic [9:0]       hit_y_q, hit_y_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign ov = video_on & goose & obstacle;

  frame_overlap_acc #(
    .CNT_W (CNT_W)
  ) u_acc (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (restart),
    .ov_i         (ov),
    .frame_tick_i (frame_tick),
    .x_i          (x),
    .y_i          (y),
    .acc_next_o   (acc_next),
    .fx_o         (fx),
    .fy_o         (fy),
    .valid_o      (f_valid)
  );

  // Compare at 32 bits so a threshold above the counter range simply never fires.
  assign over_thr = 32'(acc_next) >= 32'(HIT_THRESHOLD);

  always_comb begin
    state_d     = state_q;
    grace_d     = grace_q;
    check_hit_d = check_hit_q;
    hit_pulse_d = 1'b0;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    count_d     = count_q;

    if (restart) begin
      state_d     = RESET_ST;
      grace_d     = GRACE_INIT;
      check_hit_d = 1'b0;
      hit_x_d     = '0;
      hit_y_d     = '0;
      count_d     = '0;
    end else if (frame_tick) begin
      count_d = acc_next;
      unique case (state_q)
        ST_GRACE: begin
          grace_d = grace_q - GW'(1);
          if (grace_q <= GW'(1)) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (over_thr) begin
            state_d     = ST_HIT;
            check_hit_d = 1'b1;
            hit_pulse_d = 1'b1;
            // No captured pixel means the only overlap landed on the tick cycle itself.
            hit_x_d     = f_valid ? fx : x;
            hit_y_d     = f_valid ? fy : y;
          end
        end
        ST_HIT: begin
          state_d = ST_HIT;
        end
        default: begin
          state_d = RESET_ST;
          grace_d = GRACE_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_ST;
      grace_q     <= GRACE_INIT;
      check_hit_q <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_x_q     <= '0;
      hit_y_q     <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      grace_q     <= grace_d;
      check_hit_q <= check_hit_d;
      hit_pulse_q <= hit_pulse_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      count_q     <= count_d;
    end
  end

  assign check_hit     = check_hit_q;
  assign hit_pulse     = hit_pulse_q;
  assign hit_x         = hit_x_q;
  assign hit_y         = hit_y_q;
  assign overlap_count = count_q;

endmodule
